// File: rtl/ila_capture.sv
`default_nettype none
// ============================================================================
// Module   : ila_capture
// Brief    : Parametrised logic-analyser capture core. Circular sample buffer
//            with pre-trigger history and a chronological read port.
// Revision : 1.0 - initial release
// ============================================================================
module ila_capture #(
    parameter int PROBE_WIDTH = 8,
    parameter int DEPTH       = 1024,
    parameter int PRETRIG     = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PROBE_WIDTH-1:0]   probe,
    input  logic                     arm,
    input  logic                     trig_mode,
    input  logic [PROBE_WIDTH-1:0]   trig_mask,
    input  logic [PROBE_WIDTH-1:0]   trig_value,
    output logic [2:0]               state,
    output logic                     done,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [PROBE_WIDTH-1:0]   rd_data
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILLING   = 3'd1;
    localparam logic [2:0] S_ARMED     = 3'd2;
    localparam logic [2:0] S_CAPTURING = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [AW-1:0] C_PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] C_PRE       = AW'(PRETRIG);
    localparam logic [AW-1:0] C_POST_INIT = AW'(DEPTH - PRETRIG - 1);
    localparam logic [AW-1:0] C_FILL_LAST = AW'((PRETRIG == 0) ? 0 : PRETRIG - 1);

    logic [2:0]             state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          fill_cnt_q, fill_cnt_d;
    logic [AW-1:0]          post_cnt_q, post_cnt_d;
    logic [AW-1:0]          start_ptr_q, start_ptr_d;
    logic [PROBE_WIDTH-1:0] prev_probe_q, prev_probe_d;
    logic [PROBE_WIDTH-1:0] rd_data_q;

    logic                   wr_en;
    logic                   level_hit;
    logic                   edge_hit;
    logic                   trig_hit;
    logic [AW-1:0]          rd_idx;

    logic [PROBE_WIDTH-1:0] mem [0:DEPTH-1];

    always_comb begin
        level_hit = ((probe ^ trig_value) & trig_mask) == '0;
        edge_hit  = ((probe ^ prev_probe_q) & trig_mask) != '0;
        trig_hit  = trig_mode ? edge_hit : level_hit;
        rd_idx    = start_ptr_q + rd_addr;
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        post_cnt_d   = post_cnt_q;
        start_ptr_d  = start_ptr_q;
        prev_probe_d = prev_probe_q;
        wr_en        = 1'b0;

        if (arm) begin
            // Restart wins over any transition or trigger in the same cycle.
            prev_probe_d = probe;
            wr_ptr_d     = '0;
            fill_cnt_d   = '0;
            post_cnt_d   = '0;
            start_ptr_d  = '0;
            state_d      = (PRETRIG == 0) ? S_ARMED : S_FILLING;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_FILLING: begin
                    wr_en        = 1'b1;
                    wr_ptr_d     = wr_ptr_q + C_PTR_ONE;
                    fill_cnt_d   = fill_cnt_q + C_PTR_ONE;
                    prev_probe_d = probe;
                    if (fill_cnt_q == C_FILL_LAST) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    wr_en        = 1'b1;
                    wr_ptr_d     = wr_ptr_q + C_PTR_ONE;
                    prev_probe_d = probe;
                    if (trig_hit) begin
                        // The sample written now is the trigger sample.
                        start_ptr_d = wr_ptr_q - C_PRE;
                        post_cnt_d  = C_POST_INIT;
                        state_d     = (C_POST_INIT == '0) ? S_DONE : S_CAPTURING;
                    end
                end
                S_CAPTURING: begin
                    wr_en        = 1'b1;
                    wr_ptr_d     = wr_ptr_q + C_PTR_ONE;
                    post_cnt_d   = post_cnt_q - C_PTR_ONE;
                    prev_probe_d = probe;
                    if (post_cnt_q == C_PTR_ONE) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            start_ptr_q  <= '0;
            prev_probe_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            start_ptr_q  <= start_ptr_d;
            prev_probe_q <= prev_probe_d;
        end
    end

    // Buffer kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= probe;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign state   = state_q;
    assign done    = (state_q == S_DONE);
    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: doc/ila_capture.md
Name: ila_capture

Overview:
- Parametrised capture core: successor to the fixed-probe ILA.
- Samples a PROBE_WIDTH-bit probe bus into a circular DEPTH-entry buffer every clock.
- Keeps PRETRIG samples of history before a programmable trigger, plus DEPTH-PRETRIG samples from the trigger onward.
- Sits between user probes and the UART readout bridge; the bridge reads the result through a chronological-address read port.

Parameters:
- PROBE_WIDTH, 8: probe bus width, 1..256.
- DEPTH, 1024: buffer entries; power of two, at least 2.
- PRETRIG, 256: samples retained before the trigger sample; 0 <= PRETRIG < DEPTH.

Ports:
- clk  in  1  capture clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- probe  in  PROBE_WIDTH  signals sampled each cycle.
- arm  in  1  single-cycle pulse; starts or restarts a capture from any state.
- trig_mode  in  1  0 = level match, 1 = edge (any masked bit changed).
- trig_mask  in  PROBE_WIDTH  bits participating in the trigger.
- trig_value  in  PROBE_WIDTH  match value for level mode.
- state  out  3  IDLE=0, FILLING=1, ARMED=2, CAPTURING=3, DONE=4.
- done  out  1  high while state==DONE.
- rd_addr  in  clog2(DEPTH)  chronological index; 0 = oldest sample.
- rd_data  out  PROBE_WIDTH  sample at rd_addr, registered.

Behaviour:
- Reset, asynchronous: state=IDLE, done=0, rd_data=0, wr_ptr=0, counters=0, prev_probe=0. Buffer contents are not reset.
- Trigger and control inputs are sampled when used; they need not be held stable.
- arm seen in any state:
  - prev_probe<=probe; wr_ptr and counters cleared.
  - Next state is FILLING, or ARMED if PRETRIG==0.
  - arm has priority over every other transition in that cycle, including a trigger.
- FILLING:
  - Each cycle write probe to mem[wr_ptr]; wr_ptr++; fill_cnt++.
  - Triggers are ignored.
  - After PRETRIG writes, go to ARMED.
- ARMED:
  - Each cycle write probe to mem[wr_ptr]; wr_ptr++, wrapping at DEPTH.
  - Level trigger: (probe & trig_mask) == (trig_value & trig_mask).
  - Edge trigger: ((probe ^ prev_probe) & trig_mask) != 0.
  - On a trigger, the sample written this cycle is the trigger sample. Latch start_ptr = (wr_ptr - PRETRIG) mod DEPTH and post_cnt = DEPTH-PRETRIG-1.
  - Next state is CAPTURING, or DONE if post_cnt==0.
- CAPTURING:
  - Write each cycle and decrement post_cnt.
  - Enter DONE after the write that brings post_cnt to 0.
- DONE: no writes; the buffer is frozen.
- prev_probe<=probe every cycle in FILLING, ARMED and CAPTURING.
- Empty trigger mask:
  - Level mode with trig_mask==0 triggers on the first ARMED cycle.
  - Edge mode with trig_mask==0 never triggers.
- Readout:
  - rd_data <= mem[(start_ptr + rd_addr) mod DEPTH]; latency 1 cycle.
  - Valid only while done=1.
  - Index PRETRIG is always the trigger sample.
- The first sample is taken on the cycle after arm is seen.
- Reset mid-capture aborts to IDLE. No partial-capture readout is guaranteed.
- Buffer: single write port and single registered read port; must infer block RAM.

Test Plan:
(Common setup: PROBE_WIDTH=8, DEPTH=16, PRETRIG=4; probe = 8-bit free-running counter; arm pulsed while probe=0x10.)
- Level trigger: mask 0xFF, value 0x20 -> states FILLING(4 cyc) then ARMED then CAPTURING(11 cyc) then DONE. rd_addr 0..15 returns 0x1C..0x2B; rd_addr 4 = 0x20; data appears 1 cycle after rd_addr.
- Trigger inside the fill window: mask 0xFF, value 0x12 -> the 0x12 match during FILLING is ignored; trigger fires 256 cycles later on the next 0x12. Readout 0x0E..0x1D.
- Edge mode: mask 0x08 -> trigger on sample 0x18 (bit 3 rises). Readout 0x14..0x23; index 4 = 0x18.
- Level mode, mask 0x00 -> immediate trigger on the first ARMED sample 0x15. Readout 0x11..0x20.
- Reset and re-arm:
  - rst_n low for 1 cycle during CAPTURING -> state=0, done=0, rd_data=0 immediately (asynchronous).
  - After DONE, arm again with value 0x40 -> done drops the next cycle; new readout 0x3C..0x4B.
- PRETRIG=0 variant: state goes IDLE->ARMED directly; value 0x20 -> readout 0x20..0x2F.
